// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS-I bus CPU: opcodes, function codes,
// the control FSM state type and the instruction field layout.
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    // R-type view; the I-type immediate is {rd, shamt, funct}.
    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_cpu_bus_core_if.sv
// Avalon-style unified memory bus between the CPU (master) and memory (slave).
interface mips_cpu_bus_core_if;

    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    modport master (
        output address, write, read, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, write, read, writedata, byteenable,
        output waitrequest, readdata
    );

endinterface

// File: rtl/mips_regfile.sv
// 32x32 general purpose register file: two asynchronous read ports, one synchronous
// write port, $0 hardwired to zero, and a live tap of $2 for debug.
module mips_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] v0
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Writes to $0 are dropped here, so regs_q[0] never leaves its reset value.
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != 5'd0)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];
    assign v0      = regs_q[2];

endmodule

// File: rtl/mips_cpu_bus_core.sv
// Multicycle MIPS-I subset CPU on a single unified Avalon-style bus. Boots at
// RESET_VECTOR, honours the branch delay slot and halts when it fetches from address 0.
module mips_cpu_bus_core
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       active,
    output logic [31:0]                register_v0,
    mips_cpu_bus_core_if.master        bus
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic        br_pending_q, br_pending_d;
    logic [31:0] br_target_q, br_target_d;

    instr_t      ins;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic [31:0] eff_addr;
    logic        is_lw;
    logic        is_sw;

    logic [31:0] alu_result;
    logic        alu_we;
    logic [4:0]  alu_dest;
    logic        take_branch;
    logic [31:0] branch_dest;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign ins      = ir_q;
    assign imm      = ir_q[15:0];
    assign imm_sext = sext16(imm);
    assign imm_zext = {16'h0000, imm};
    assign pc_plus4 = pc_q + 32'd4;
    assign pc_plus8 = pc_q + 32'd8;
    assign eff_addr = rs_val + imm_sext;
    assign is_lw    = (ins.op == OP_LW);
    assign is_sw    = (ins.op == OP_SW);

    mips_regfile u_regfile (
        .clk     (clk),
        .rst_n   (reset),
        .raddr_a (ins.rs),
        .raddr_b (ins.rt),
        .rdata_a (rs_val),
        .rdata_b (rt_val),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .v0      (register_v0)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_VECTOR;
            ir_q         <= '0;
            br_pending_q <= 1'b0;
            br_target_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            br_pending_q <= br_pending_d;
            br_target_q  <= br_target_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (pc_q == 32'h0) begin
                    state_d = S_HALT;
                end else if (!bus.waitrequest) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC:   state_d = (is_lw || is_sw) ? S_MEM : S_FETCH;
            S_MEM: begin
                if (!bus.waitrequest) begin
                    state_d = is_lw ? S_WB : S_FETCH;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // Execute-stage decode: ALU result, its destination, and any control transfer.
    always_comb begin
        alu_result  = '0;
        alu_we      = 1'b0;
        alu_dest    = ins.rd;
        take_branch = 1'b0;
        branch_dest = pc_plus4 + {imm_sext[29:0], 2'b00};
        case (ins.op)
            OP_SPECIAL: begin
                alu_we = 1'b1;
                case (ins.funct)
                    FN_SLL:  alu_result = rt_val << ins.shamt;
                    FN_SRL:  alu_result = rt_val >> ins.shamt;
                    FN_SRA:  alu_result = $signed(rt_val) >>> ins.shamt;
                    FN_SLLV: alu_result = rt_val << rs_val[4:0];
                    FN_SRLV: alu_result = rt_val >> rs_val[4:0];
                    FN_SRAV: alu_result = $signed(rt_val) >>> rs_val[4:0];
                    FN_ADDU: alu_result = rs_val + rt_val;
                    FN_SUBU: alu_result = rs_val - rt_val;
                    FN_AND:  alu_result = rs_val & rt_val;
                    FN_OR:   alu_result = rs_val | rt_val;
                    FN_XOR:  alu_result = rs_val ^ rt_val;
                    FN_NOR:  alu_result = ~(rs_val | rt_val);
                    FN_SLT:  alu_result = {31'b0, $signed(rs_val) < $signed(rt_val)};
                    FN_SLTU: alu_result = {31'b0, rs_val < rt_val};
                    FN_JR: begin
                        alu_we      = 1'b0;
                        take_branch = 1'b1;
                        branch_dest = rs_val;
                    end
                    FN_JALR: begin
                        alu_result  = pc_plus8;
                        take_branch = 1'b1;
                        branch_dest = rs_val;
                    end
                    default: alu_we = 1'b0;
                endcase
            end
            OP_J: begin
                take_branch = 1'b1;
                branch_dest = {pc_plus4[31:28], ir_q[25:0], 2'b00};
            end
            OP_JAL: begin
                take_branch = 1'b1;
                branch_dest = {pc_plus4[31:28], ir_q[25:0], 2'b00};
                alu_result  = pc_plus8;
                alu_we      = 1'b1;
                alu_dest    = 5'd31;
            end
            OP_BEQ: take_branch = (rs_val == rt_val);
            OP_BNE: take_branch = (rs_val != rt_val);
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                alu_we   = 1'b1;
                alu_dest = ins.rt;
                case (ins.op)
                    OP_ADDIU: alu_result = rs_val + imm_sext;
                    OP_SLTI:  alu_result = {31'b0, $signed(rs_val) < $signed(imm_sext)};
                    OP_SLTIU: alu_result = {31'b0, rs_val < imm_sext};
                    OP_ANDI:  alu_result = rs_val & imm_zext;
                    OP_ORI:   alu_result = rs_val | imm_zext;
                    OP_XORI:  alu_result = rs_val ^ imm_zext;
                    default:  alu_result = {imm, 16'h0000};
                endcase
            end
            default: ;
        endcase
    end

    // A pending target from the previous instruction wins over PC+4; that is the delay slot.
    always_comb begin
        pc_d         = pc_q;
        ir_d         = ir_q;
        br_pending_d = br_pending_q;
        br_target_d  = br_target_q;
        if (state_q == S_DECODE) begin
            ir_d = bus.readdata;
        end
        if (state_q == S_EXEC) begin
            pc_d         = br_pending_q ? br_target_q : pc_plus4;
            br_pending_d = take_branch;
            br_target_d  = branch_dest;
        end
    end

    always_comb begin
        rf_we    = (state_q == S_WB) || ((state_q == S_EXEC) && alu_we);
        rf_waddr = (state_q == S_WB) ? ins.rt : alu_dest;
        rf_wdata = (state_q == S_WB) ? bus.readdata : alu_result;
    end

    // Strobes are gated by reset so an in-flight access is dropped as soon as reset asserts.
    always_comb begin
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = {pc_q[31:2], 2'b00};
        bus.writedata  = rt_val;
        bus.byteenable = 4'b1111;
        case (state_q)
            S_FETCH: bus.read = reset && (pc_q != 32'h0);
            S_MEM: begin
                bus.address = {eff_addr[31:2], 2'b00};
                bus.read    = reset && is_lw;
                bus.write   = reset && is_sw;
            end
            default: ;
        endcase
    end

    assign active = (state_q != S_HALT);

endmodule

// File: tb/tb_mips_cpu_bus_core.sv
// Self-checking bench: runs a table of small programs from a bus memory model and
// scoreboards final $v0 and every accepted store, plus hand-written stall/reset cases.
module tb_mips_cpu_bus_core;

    localparam logic [31:0] RV = 32'hBFC0_0000;
    localparam int NVEC = 8;

    typedef struct packed {
        logic [15:0][31:0] prog;
        logic [31:0]       exp_v0;
        logic              exp_wr;
        logic [31:0]       wr_addr;
        logic [31:0]       wr_data;
        logic              stall;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        active;
    logic [31:0] register_v0;

    mips_cpu_bus_core_if bus ();

    mips_cpu_bus_core dut (
        .clk         (clk),
        .reset       (reset),
        .active      (active),
        .register_v0 (register_v0),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t        vecs [NVEC];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_v0_q [$];
    wr_t         exp_wr_q [$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic        force_wait = 1'b0;
    logic        rand_stall = 1'b0;
    logic        acc_rd = 1'b0;
    logic        acc_wr = 1'b0;
    logic [31:0] acc_addr = '0;
    logic [31:0] acc_data = '0;

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input int sh, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int op, input logic [31:0] target);
        return {6'(op), target[27:2]};
    endfunction

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %08h required %08h", name, act, exp);
        end
    endtask

    // Memory slave: accepted accesses are captured at negedge, serviced just after posedge.
    initial begin
        bus.waitrequest = 1'b0;
        bus.readdata    = '0;
        forever begin
            @(posedge clk);
            #1;
            if (acc_wr) mem[acc_addr] = acc_data;
            if (acc_rd) bus.readdata = mem.exists(acc_addr) ? mem[acc_addr] : 32'h0;
            bus.waitrequest = force_wait || (rand_stall && ($urandom_range(0, 2) == 0));
        end
    end

    always @(negedge clk) begin
        wr_t e;
        acc_rd   = bus.read && !bus.waitrequest;
        acc_wr   = bus.write && !bus.waitrequest;
        acc_addr = bus.address;
        acc_data = bus.writedata;
        if (bus.read && bus.write) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL strobe_excl: got read=1 write=1 required at most one");
        end
        if (acc_wr) begin
            if (exp_wr_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL unexpected_write: got addr %08h data %08h required none",
                         bus.address, bus.writedata);
            end else begin
                e = exp_wr_q.pop_front();
                compare("wr_addr", bus.address, e.addr);
                compare("wr_data", bus.writedata, e.data);
                compare("wr_be", {28'h0, bus.byteenable}, 32'h0000000F);
            end
        end
    end

    task automatic load_vec(input int k);
        wr_t w;
        mem.delete();
        for (int i = 0; i < 16; i++) begin
            mem[RV + 32'(4 * i)] = vecs[k].prog[i];
        end
        exp_v0_q.push_back(vecs[k].exp_v0);
        if (vecs[k].exp_wr) begin
            w.addr = vecs[k].wr_addr;
            w.data = vecs[k].wr_data;
            exp_wr_q.push_back(w);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_halt(input int idx);
        int cyc;
        cyc = 0;
        while (active && (cyc < 10000)) begin
            @(negedge clk);
            cyc++;
        end
        if (active) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL v%0d_timeout: got active=1 after %0d cycles required 0", idx, cyc);
        end
    endtask

    task automatic applyStimulus(input int k);
        rand_stall = vecs[k].stall;
        load_vec(k);
        pulse_reset();
        wait_halt(k);
    endtask

    task automatic checkOutput(input int idx);
        logic [31:0] ev;
        if (exp_v0_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL v%0d_v0: got %08h required <no expectation queued>", idx, register_v0);
        end else begin
            ev = exp_v0_q.pop_front();
            compare($sformatf("v%0d_v0", idx), register_v0, ev);
        end
        compare($sformatf("v%0d_wr_pending", idx), 32'(exp_wr_q.size()), 32'h0);
        exp_wr_q.delete();
        @(negedge clk);
        compare($sformatf("v%0d_halt_strobes", idx), {30'h0, bus.read, bus.write}, 32'h0);
        compare($sformatf("v%0d_active", idx), {31'h0, active}, 32'h0);
    endtask

    initial begin
        int cyc;
        reset = 1'b0;
        for (int k = 0; k < NVEC; k++) vecs[k] = '0;

        vecs[0].prog[0]  = 32'h3C08BFC0;
        vecs[0].prog[1]  = 32'h00000008;
        vecs[0].prog[2]  = 32'h8D02002C;
        vecs[0].prog[11] = 32'h0000000A;
        vecs[0].exp_v0   = 32'h0000000A;

        vecs[1].prog[0] = enc_i('h0F, 0, 8, 'hBFC0);
        vecs[1].prog[1] = enc_i('h0D, 0, 2, 5);
        vecs[1].prog[2] = enc_i('h2B, 8, 2, 'h40);
        vecs[1].prog[3] = enc_i('h0D, 0, 2, 7);
        vecs[1].prog[4] = enc_i('h23, 8, 2, 'h40);
        vecs[1].prog[5] = 32'h00000008;
        vecs[1].exp_v0  = 32'h00000005;
        vecs[1].exp_wr  = 1'b1;
        vecs[1].wr_addr = 32'hBFC00040;
        vecs[1].wr_data = 32'h00000005;

        vecs[2].prog[0] = enc_i('h04, 0, 0, 2);
        vecs[2].prog[1] = enc_i('h09, 2, 2, 1);
        vecs[2].prog[2] = enc_i('h09, 2, 2, 16);
        vecs[2].prog[3] = 32'h00000008;
        vecs[2].exp_v0  = 32'h00000001;

        vecs[3].prog[0] = enc_j('h03, 32'hBFC00010);
        vecs[3].prog[1] = enc_i('h09, 2, 2, 1);
        vecs[3].prog[2] = 32'h00000008;
        vecs[3].prog[3] = enc_i('h09, 2, 2, 1);
        vecs[3].prog[4] = enc_r(31, 0, 0, 0, 'h08);
        vecs[3].prog[5] = enc_i('h09, 2, 2, 1);
        vecs[3].exp_v0  = 32'h00000003;

        vecs[4].prog[0]  = enc_i('h0D, 0, 3, 'hF0);
        vecs[4].prog[1]  = enc_i('h0F, 0, 4, 'h8000);
        vecs[4].prog[2]  = enc_r(0, 4, 5, 4, 'h03);
        vecs[4].prog[3]  = enc_r(0, 4, 6, 4, 'h02);
        vecs[4].prog[4]  = enc_r(5, 6, 2, 0, 'h26);
        vecs[4].prog[5]  = enc_r(4, 3, 7, 0, 'h2A);
        vecs[4].prog[6]  = enc_r(2, 7, 2, 0, 'h21);
        vecs[4].prog[7]  = enc_r(4, 3, 9, 0, 'h2B);
        vecs[4].prog[8]  = enc_r(2, 9, 2, 0, 'h21);
        vecs[4].prog[9]  = enc_r(2, 3, 2, 0, 'h23);
        vecs[4].prog[10] = 32'h00000008;
        vecs[4].exp_v0   = 32'hEFFFFF11;

        vecs[5].prog[0]  = enc_i('h09, 0, 3, 'hFFFF);
        vecs[5].prog[1]  = enc_i('h0C, 3, 4, 'hFFFF);
        vecs[5].prog[2]  = enc_i('h0D, 0, 5, 8);
        vecs[5].prog[3]  = enc_r(5, 4, 6, 0, 'h04);
        vecs[5].prog[4]  = enc_r(5, 3, 10, 0, 'h06);
        vecs[5].prog[5]  = enc_r(6, 0, 11, 0, 'h27);
        vecs[5].prog[6]  = enc_r(11, 10, 2, 0, 'h24);
        vecs[5].prog[7]  = enc_i('h0E, 2, 2, 'h8000);
        vecs[5].prog[8]  = enc_i('h0A, 3, 13, 1);
        vecs[5].prog[9]  = enc_r(0, 13, 13, 4, 'h00);
        vecs[5].prog[10] = enc_r(2, 13, 2, 0, 'h21);
        vecs[5].prog[11] = enc_i('h0B, 4, 12, 'hFFFF);
        vecs[5].prog[12] = enc_r(2, 12, 2, 0, 'h21);
        vecs[5].prog[13] = 32'h00000008;
        vecs[5].exp_v0   = 32'h00008110;
        vecs[5].stall    = 1'b1;

        vecs[6].prog[0]  = enc_i('h09, 0, 0, 5);
        vecs[6].prog[1]  = enc_r(0, 0, 2, 0, 'h21);
        vecs[6].prog[2]  = enc_i('h05, 2, 0, 3);
        vecs[6].prog[3]  = enc_i('h09, 2, 2, 2);
        vecs[6].prog[4]  = enc_i('h05, 2, 0, 2);
        vecs[6].prog[5]  = enc_i('h09, 2, 2, 5);
        vecs[6].prog[6]  = enc_i('h09, 2, 2, 64);
        vecs[6].prog[7]  = enc_i('h0F, 0, 9, 'hBFC0);
        vecs[6].prog[8]  = enc_i('h0D, 9, 9, 'h30);
        vecs[6].prog[9]  = enc_r(9, 0, 10, 0, 'h09);
        vecs[6].prog[10] = enc_i('h09, 2, 2, 8);
        vecs[6].prog[11] = enc_i('h09, 2, 2, 64);
        vecs[6].prog[12] = enc_r(10, 9, 11, 0, 'h23);
        vecs[6].prog[13] = enc_r(2, 11, 2, 0, 'h21);
        vecs[6].prog[14] = enc_i('h3F, 0, 2, 'h1234);
        vecs[6].prog[15] = 32'h00000008;
        vecs[6].exp_v0   = 32'h0000000B;
        vecs[6].stall    = 1'b1;

        vecs[7]       = vecs[1];
        vecs[7].stall = 1'b1;

        repeat (2) @(negedge clk);
        for (int k = 0; k < NVEC; k++) begin
            applyStimulus(k);
            checkOutput(k);
        end
        rand_stall = 1'b0;

        // Fetch held off by waitrequest: address and read must not move.
        force_wait = 1'b1;
        load_vec(0);
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compare("hold_addr", bus.address, RV);
            compare("hold_read", {31'h0, bus.read}, 32'h1);
        end
        force_wait = 1'b0;
        wait_halt(8);
        checkOutput(8);

        // Reset asserted while a read is outstanding, then a clean restart.
        load_vec(4);
        pulse_reset();
        repeat (20) @(negedge clk);
        cyc = 0;
        while (!bus.read && (cyc < 100)) begin
            @(negedge clk);
            cyc++;
        end
        compare("midrst_read_seen", {31'h0, bus.read}, 32'h1);
        reset = 1'b0;
        #1;
        compare("midrst_strobes", {30'h0, bus.read, bus.write}, 32'h0);
        compare("midrst_active", {31'h0, active}, 32'h1);
        compare("midrst_v0", register_v0, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        compare("boot_active", {31'h0, active}, 32'h1);
        compare("boot_read", {31'h0, bus.read}, 32'h1);
        compare("boot_addr", bus.address, RV);
        wait_halt(9);
        checkOutput(9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
